// File: rtl/mips32_reg_dump.sv
// mips32_reg_dump: scans the register file on halt or start and streams tagged words with an XOR checksum
module mips32_reg_dump #(
  parameter int NREGS  = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              halted,
  input  logic              start,
  output logic              rf_en,
  output logic [4:0]        rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] csum
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;
  localparam logic [4:0] LAST = 5'(NREGS - 1);
  state_t state_q, state_d;
  logic [4:0] idx_q, idx_d, out_idx_q, out_idx_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, csum_q, csum_d;
  logic halted_q, trig;
  assign trig = start | (halted & ~halted_q);
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
      csum_q     <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
      csum_q     <= csum_d;
      halted_q   <= halted;
    end
  end
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    csum_d     = csum_q;
    case (state_q)
      IDLE, DONE: if (trig) begin
        state_d = READ;
        idx_d   = '0;
        csum_d  = '0;
      end
      READ: state_d = WAIT;
      WAIT: begin
        state_d    = SEND;
        out_data_d = rf_data;
        out_idx_d  = idx_q;
        csum_d     = csum_q ^ rf_data;
      end
      SEND: if (out_ready) begin
        state_d = (idx_q == LAST) ? DONE : READ;
        idx_d   = (idx_q == LAST) ? idx_q : idx_q + 5'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rf_en     = state_q == READ;
    rf_addr   = idx_q;
    out_valid = state_q == SEND;
    out_data  = out_data_q;
    out_idx   = out_idx_q;
    out_last  = (state_q == SEND) && (out_idx_q == LAST);
    busy      = (state_q == READ) || (state_q == WAIT) || (state_q == SEND);
    done      = state_q == DONE;
    csum      = csum_q;
  end
endmodule

// File: tb/tb_mips32_reg_dump.sv
// tb_mips32_reg_dump: scoreboard bench for the register dump engine, full-size and NREGS=4 instances
module tb_mips32_reg_dump;
  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, halted, start, out_ready, rf_en, out_valid, out_last, busy, done;
  logic [4:0] rf_addr, out_idx;
  logic [31:0] rf_data, out_data, csum;
  logic [31:0] rf [32];
  logic start4, halted4, ready4, rf_en4, out_valid4, out_last4, busy4, done4;
  logic [4:0] rf_addr4, out_idx4;
  logic [31:0] rf_data4, out_data4, csum4;
  logic [31:0] rf4 [4];
  exp_t q[$], q4[$];
  int checks = 0, failures = 0;
  logic stalled_q = 1'b0;
  logic [31:0] held_data;
  logic [4:0] held_idx;
  logic [3:0] pat = 4'b1001;
  mips32_reg_dump u_dut (
    .clk1(clk), .rst(rst), .halted(halted), .start(start),
    .rf_en(rf_en), .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .done(done), .csum(csum)
  );
  mips32_reg_dump #(.NREGS(4), .DATA_W(32)) u_dut4 (
    .clk1(clk), .rst(rst), .halted(halted4), .start(start4),
    .rf_en(rf_en4), .rf_addr(rf_addr4), .rf_data(rf_data4),
    .out_valid(out_valid4), .out_ready(ready4), .out_data(out_data4), .out_idx(out_idx4),
    .out_last(out_last4), .busy(busy4), .done(done4), .csum(csum4)
  );
  always @(posedge clk) if (rf_en) rf_data <= rf[rf_addr];
  always @(posedge clk) if (rf_en4) rf_data4 <= rf4[rf_addr4[1:0]];
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction
  always @(negedge clk) begin
    if (rst) stalled_q <= 1'b0;
    else begin
      if (out_valid && stalled_q) begin
        chk("stall data held", out_data, held_data);
        chk("stall idx held", 32'(out_idx), 32'(held_idx));
      end
      chk("rf_en during send", 32'(rf_en & out_valid), 0);
      chk("out_last without valid", 32'(out_last & ~out_valid), 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious word: got idx %0d expected none", out_idx);
        end else begin
          chk("word idx", 32'(out_idx), 32'(q[0].idx));
          chk("word data", out_data, q[0].data);
          chk("word last", 32'(out_last), 32'(q[0].last));
          void'(q.pop_front());
        end
      end
      stalled_q <= out_valid && !out_ready;
      held_data <= out_data;
      held_idx  <= out_idx;
    end
  end
  always @(negedge clk) begin
    if (!rst && out_valid4 && ready4) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious word n4: got idx %0d expected none", out_idx4);
      end else begin
        chk("n4 idx", 32'(out_idx4), 32'(q4[0].idx));
        chk("n4 data", out_data4, q4[0].data);
        chk("n4 last", 32'(out_last4), 32'(q4[0].last));
        void'(q4.pop_front());
      end
    end
  end
  task automatic do_dump(input int mode, input bit bp, input int hook, input logic [31:0] exp_csum);
    int cyc, k;
    bit fin, aborted, pend, fired, seen4;
    for (int i = 0; i < 32; i++) q.push_back('{5'(i), rf[i], i == 31});
    @(posedge clk);
    #1;
    start  = (mode != 1);
    halted = (mode != 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    out_ready = 1'b1;
    cyc = 0; k = 0; fin = 0; aborted = 0; pend = 0; fired = 0; seen4 = 0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("rf_en at T+1", 32'(rf_en), 1);
        chk("rf_addr at T+1", 32'(rf_addr), 0);
        chk("done cleared", 32'(done), 0);
        chk("busy at T+1", 32'(busy), 1);
      end
      if (hook == 1 && !fired && out_valid && out_idx == 5'd10) begin
        fired = 1;
        pend = 1;
      end
      if (hook == 2 && out_valid && out_ready && out_idx == 5'd4) seen4 = 1;
      if (hook == 2 && out_valid && !out_ready && out_idx == 5'd5) begin
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst csum", csum, 0);
        chk("rst out_idx", 32'(out_idx), 0);
        q.delete();
        aborted = 1;
        fin = 1;
      end else if (done) fin = 1;
      else if (cyc > 3000) begin
        checks++;
        failures++;
        $display("FAIL dump timeout: got no done after %0d cycles expected done", cyc);
        aborted = 1;
        fin = 1;
      end else begin
        @(posedge clk);
        #1;
        start = pend;
        pend = 0;
        out_ready = (hook == 2 && seen4) ? 1'b0 : bp ? pat[k % 4] : 1'b1;
        k++;
      end
    end
    out_ready = 1'b1;
    if (!aborted) begin
      if (!bp) chk("done cycle", 32'(cyc), 97);
      chk("csum", csum, exp_csum);
      chk("queue drained", 32'(q.size()), 0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int cyc, bad;
    rst = 1'b1; start = 1'b0; halted = 1'b0; out_ready = 1'b1;
    start4 = 1'b0; halted4 = 1'b0; ready4 = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1] = 32'd29; rf[2] = 32'd4; rf[3] = 32'd8; rf[5] = 32'd0; rf[10] = 32'd1;
    rf4[0] = 32'h0; rf4[1] = 32'h1d; rf4[2] = 32'h4; rf4[3] = 32'h8;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset rf_en", 32'(rf_en), 0);
    chk("reset rf_addr", 32'(rf_addr), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_idx", 32'(out_idx), 0);
    chk("reset out_last", 32'(out_last), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset csum", csum, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 begin rst = 1'b1; start = 1'b1; end
    @(posedge clk);
    #1 begin rst = 1'b0; start = 1'b0; end
    @(negedge clk);
    chk("trigger with rst busy", 32'(busy), 0);
    chk("trigger with rst rf_en", 32'(rf_en), 0);
    do_dump(0, 0, 0, 32'h10);
    do_dump(0, 0, 1, 32'h10);
    do_dump(0, 0, 0, 32'h10);
    do_dump(0, 1, 0, 32'h10);
    do_dump(1, 0, 0, 32'h10);
    bad = 0;
    repeat (170) begin
      @(negedge clk);
      if (busy) bad++;
    end
    chk("halt single dump", 32'(bad), 0);
    @(posedge clk);
    #1 halted = 1'b0;
    repeat (2) @(posedge clk);
    do_dump(2, 0, 0, 32'h10);
    @(posedge clk);
    #1 halted = 1'b0;
    do_dump(0, 0, 2, 32'h10);
    do_dump(0, 0, 0, 32'h10);
    for (int i = 0; i < 4; i++) q4.push_back('{5'(i), rf4[i], i == 3});
    @(posedge clk);
    #1 start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("n4 done cycle", 32'(cyc), 13);
    chk("n4 csum", csum4, 32'h11);
    chk("n4 queue drained", 32'(q4.size()), 0);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
